// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder slice.
package serial_adder_pkg;

    // Default operand/result width.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bits needed to count 0..width inclusive (ceil(log2(width+1))), minimum 1.
    function automatic int unsigned cnt_bits(input int unsigned width);
        int unsigned bits;
        bits = $clog2(width + 1);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial adder's bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    // Propagate term shared by sum and carry.
    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b, cin on start and produces a+b+cin one bit
// per clock through a single full adder, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = cnt_bits(WIDTH);

    // State encodings kept local to this module.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_accept;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Single bit slice fed by the operand LSBs and the carry flop.
    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    // Start is honoured only when not already running.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Final RUN edge: the counter has seen WIDTH-1 bits already.
    assign w_last = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status flags decoded from the upcoming state so they can be registered.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt == S_RUN) begin
            w_busy_nxt = 1'b1;
        end
        if (w_state_nxt == S_DONE) begin
            w_done_nxt = 1'b1;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand shift registers, carry flop, partial result and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_nxt;
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result outputs load only on the transition into DONE and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_res_nxt;
            r_cout <= w_fa_c;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
